// File: rtl/ps2_keyboard_rx.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_keyboard_rx
//  Description : PS/2 keyboard receiver. Conditions the PS/2 pins, frames
//                11-bit device-to-host words, filters break (F0) and
//                extended (E0) sequences and presents key-press codes with
//                a stretched done strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_keyboard_rx #(
   parameter int FILTER_LEN = 8,
   parameter int TIMEOUT    = 50000,
   parameter int DONE_HOLD  = 800
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] tasta,
   output logic       done,
   output logic       frame_err
);

   localparam int FLT_W  = $clog2(FILTER_LEN + 1);
   localparam int TO_W   = $clog2(TIMEOUT + 1) + 1;
   localparam int HOLD_W = $clog2(DONE_HOLD + 1) + 1;

   localparam logic [FLT_W-1:0]  FLT_LAST  = FLT_W'(FILTER_LEN - 1);
   localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);
   localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(DONE_HOLD);
   localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

   localparam logic [7:0] CODE_BREAK = 8'hF0;
   localparam logic [7:0] CODE_EXT   = 8'hE0;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DATA   = 2'd1,
      S_PARITY = 2'd2,
      S_STOP   = 2'd3
   } state_t;

   // Index 0 carries ps2_clk, index 1 carries ps2_data.
   logic [1:0]       pins;
   logic [1:0]       sync1;
   logic [1:0]       sync2;
   logic [1:0]       filt;
   logic [FLT_W-1:0] flt_cnt [2];

   logic             clk_filt_q;
   logic             bit_edge;
   logic             sample;

   state_t           state;
   state_t           state_next;
   logic [3:0]       bit_cnt;
   logic [3:0]       bit_cnt_next;
   logic [7:0]       shift;
   logic [7:0]       shift_next;
   logic             par_ok;
   logic             par_ok_next;
   logic             frame_good;
   logic             frame_bad;
   logic             timeout_hit;

   logic [TO_W-1:0]  to_cnt;
   logic [HOLD_W-1:0] hold_cnt;
   logic             break_pending;

   assign pins = {ps2_data, ps2_clk};

   // Two-flop synchronizers followed by a run-length stability filter per pin;
   // a filtered line only flips after FILTER_LEN consecutive differing samples.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync1 <= 2'b11;
         sync2 <= 2'b11;
         filt  <= 2'b11;
         for (int i = 0; i < 2; i++) begin
            flt_cnt[i] <= '0;
         end
      end else begin
         sync1 <= pins;
         sync2 <= sync1;
         for (int i = 0; i < 2; i++) begin
            if (sync2[i] == filt[i]) begin
               flt_cnt[i] <= '0;
            end else if (flt_cnt[i] == FLT_LAST) begin
               filt[i]    <= sync2[i];
               flt_cnt[i] <= '0;
            end else begin
               flt_cnt[i] <= flt_cnt[i] + 1'b1;
            end
         end
      end
   end

   // Delayed copy of the filtered clock for falling-edge detection.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         clk_filt_q <= 1'b1;
      end else begin
         clk_filt_q <= filt[0];
      end
   end

   assign bit_edge    = clk_filt_q & ~filt[0];
   assign sample      = filt[1];
   assign timeout_hit = (state != S_IDLE) && !bit_edge && (to_cnt == TO_LAST);

   // Frame state register and shift/parity datapath.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state   <= S_IDLE;
         bit_cnt <= '0;
         shift   <= '0;
         par_ok  <= 1'b0;
      end else begin
         state   <= state_next;
         bit_cnt <= bit_cnt_next;
         shift   <= shift_next;
         par_ok  <= par_ok_next;
      end
   end

   // Next-state logic: start bit, 8 data bits LSB first, parity, stop.
   always_comb begin
      state_next   = state;
      bit_cnt_next = bit_cnt;
      shift_next   = shift;
      par_ok_next  = par_ok;
      frame_good   = 1'b0;
      frame_bad    = 1'b0;
      case (state)
         S_IDLE: begin
            if (bit_edge && !sample) begin
               state_next   = S_DATA;
               bit_cnt_next = '0;
            end
         end
         S_DATA: begin
            if (bit_edge) begin
               shift_next   = {sample, shift[7:1]};
               bit_cnt_next = bit_cnt + 4'd1;
               if (bit_cnt == 4'd7) begin
                  state_next = S_PARITY;
               end
            end
         end
         S_PARITY: begin
            if (bit_edge) begin
               // Odd parity: data plus parity bit must hold an odd count of ones.
               par_ok_next = ^{shift, sample};
               state_next  = S_STOP;
            end
         end
         S_STOP: begin
            if (bit_edge) begin
               state_next = S_IDLE;
               if (sample && par_ok) begin
                  frame_good = 1'b1;
               end else begin
                  frame_bad = 1'b1;
               end
            end
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
      if (timeout_hit) begin
         state_next = S_IDLE;
         frame_bad  = 1'b1;
      end
   end

   // Inter-edge watchdog: cleared on every bit edge and while idle.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         to_cnt <= '0;
      end else if (state == S_IDLE || bit_edge) begin
         to_cnt <= '0;
      end else if (to_cnt <= TO_LAST) begin
         to_cnt <= to_cnt + 1'b1;
      end
   end

   // Code decode, break filtering, error pulse and done stretching.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         tasta         <= '0;
         done          <= 1'b0;
         hold_cnt      <= '0;
         frame_err     <= 1'b0;
         break_pending <= 1'b0;
      end else begin
         frame_err <= frame_bad;

         if (done) begin
            if (hold_cnt == HOLD_ONE) begin
               done     <= 1'b0;
               hold_cnt <= '0;
            end else begin
               hold_cnt <= hold_cnt - 1'b1;
            end
         end

         if (frame_bad) begin
            break_pending <= 1'b0;
         end else if (frame_good) begin
            if (shift == CODE_BREAK) begin
               break_pending <= 1'b1;
            end else if (shift == CODE_EXT) begin
               // Extended prefix carries no key information for the game.
               break_pending <= break_pending;
            end else if (break_pending) begin
               // Release code following F0: swallow it.
               break_pending <= 1'b0;
            end else begin
               // A press overrides any done/hold updates above in this clock.
               tasta    <= shift;
               done     <= 1'b1;
               hold_cnt <= HOLD_LOAD;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ps2_keyboard_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ps2_keyboard_rx
//  Description : Directed self-checking bench for ps2_keyboard_rx.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_keyboard_rx;

   localparam int FILTER_LEN = 8;
   localparam int TIMEOUT    = 2000;
   localparam int DONE_HOLD  = 800;
   localparam int HALF       = 30;

   logic       clock;
   logic       reset;
   logic       ps2_clk;
   logic       ps2_data;
   logic [7:0] tasta;
   logic       done;
   logic       frame_err;

   int n_checks = 0;
   int n_errors = 0;

   int done_rises = 0;
   int done_run   = 0;
   int last_len   = 0;
   int err_pulses = 0;
   int err_long   = 0;
   logic done_q   = 1'b0;
   logic err_q    = 1'b0;

   ps2_keyboard_rx #(
      .FILTER_LEN (FILTER_LEN),
      .TIMEOUT    (TIMEOUT),
      .DONE_HOLD  (DONE_HOLD)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .ps2_clk   (ps2_clk),
      .ps2_data  (ps2_data),
      .tasta     (tasta),
      .done      (done),
      .frame_err (frame_err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Observe done windows and frame_err pulses away from the active edge.
   always @(negedge clock) begin
      if (done) begin
         if (!done_q) begin
            done_rises = done_rises + 1;
            done_run   = 0;
         end
         done_run = done_run + 1;
         last_len = done_run;
      end
      if (frame_err) begin
         err_pulses = err_pulses + 1;
         if (err_q) err_long = err_long + 1;
      end
      done_q = done;
      err_q  = frame_err;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks = n_checks + 1;
      if (got !== exp) begin
         n_errors = n_errors + 1;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   // Device-to-host frame; nedges < 11 truncates it, glitch adds short
   // low pulses on ps2_clk during each high phase.
   task automatic send_frame(input logic [7:0] code, input logic par_flip,
                             input logic stop_bit, input int nedges,
                             input logic glitch);
      logic [10:0] bits;
      bits = {stop_bit, (~^code) ^ par_flip, code, 1'b0};
      for (int i = 0; i < nedges; i++) begin
         ps2_data = bits[i];
         tick(HALF);
         ps2_clk = 1'b0;
         tick(HALF);
         ps2_clk = 1'b1;
         if (glitch && i < 10) begin
            tick(12);
            ps2_clk = 1'b0;
            tick(4);
            ps2_clk = 1'b1;
         end
      end
      ps2_data = 1'b1;
   endtask

   task automatic glitch_idle();
      for (int i = 0; i < 3; i++) begin
         ps2_clk = 1'b0;
         tick(4);
         ps2_clk = 1'b1;
         tick(15);
      end
   endtask

   initial begin
      reset    = 1'b0;
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
      tick(5);
      check("rst_tasta", {24'd0, tasta}, 32'h00);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_ferr", {31'd0, frame_err}, 32'd0);
      reset = 1'b1;
      tick(10);

      // Basic make code
      send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b0);
      tick(900);
      check("t1_tasta", {24'd0, tasta}, 32'h1C);
      check("t1_rises", done_rises, 1);
      check("t1_len", last_len, DONE_HOLD);
      check("t1_err", err_pulses, 0);

      // Press, break, release
      send_frame(8'h29, 1'b0, 1'b1, 11, 1'b0);
      tick(900);
      check("t2_tasta_a", {24'd0, tasta}, 32'h29);
      check("t2_rises_a", done_rises, 2);
      send_frame(8'hF0, 1'b0, 1'b1, 11, 1'b0);
      tick(100);
      send_frame(8'h29, 1'b0, 1'b1, 11, 1'b0);
      tick(900);
      check("t2_tasta_b", {24'd0, tasta}, 32'h29);
      check("t2_rises_b", done_rises, 2);
      check("t2_err", err_pulses, 0);

      // Parity error then good frame
      send_frame(8'h76, 1'b1, 1'b1, 11, 1'b0);
      tick(100);
      check("t3_err", err_pulses, 1);
      check("t3_err_width", err_long, 0);
      check("t3_rises", done_rises, 2);
      check("t3_tasta", {24'd0, tasta}, 32'h29);
      send_frame(8'h16, 1'b0, 1'b1, 11, 1'b0);
      tick(900);
      check("t3_tasta_b", {24'd0, tasta}, 32'h16);
      check("t3_rises_b", done_rises, 3);
      check("t3_len", last_len, DONE_HOLD);

      // Truncated frame (start + 5 data bits) then timeout
      send_frame(8'h55, 1'b0, 1'b1, 6, 1'b0);
      tick(TIMEOUT + 300);
      check("t4_err", err_pulses, 2);
      check("t4_rises", done_rises, 3);
      send_frame(8'h1E, 1'b0, 1'b1, 11, 1'b0);
      tick(900);
      check("t4_tasta", {24'd0, tasta}, 32'h1E);
      check("t4_rises_b", done_rises, 4);

      // Glitches in idle and between bits
      glitch_idle();
      tick(20);
      send_frame(8'h23, 1'b0, 1'b1, 11, 1'b1);
      tick(900);
      check("t5_tasta", {24'd0, tasta}, 32'h23);
      check("t5_rises", done_rises, 5);
      check("t5_err", err_pulses, 2);

      // Extended prefix ignored
      send_frame(8'hE0, 1'b0, 1'b1, 11, 1'b0);
      tick(100);
      send_frame(8'h4B, 1'b0, 1'b1, 11, 1'b0);
      tick(900);
      check("t6_tasta", {24'd0, tasta}, 32'h4B);
      check("t6_rises", done_rises, 6);

      // Back-to-back presses: one continuous done window, hold reloaded
      send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b0);
      tick(20);
      send_frame(8'h1D, 1'b0, 1'b1, 11, 1'b0);
      tick(1600);
      check("b2b_tasta", {24'd0, tasta}, 32'h1D);
      check("b2b_rises", done_rises, 7);
      check("b2b_len", last_len, 11 * 2 * HALF + 20 + DONE_HOLD);

      // Reset during bit 4 of a frame
      send_frame(8'h3B, 1'b0, 1'b1, 5, 1'b0);
      ps2_data = 1'b1;
      tick(HALF);
      ps2_clk = 1'b0;
      tick(10);
      reset = 1'b0;
      tick(2);
      check("mid_rst_tasta", {24'd0, tasta}, 32'h00);
      check("mid_rst_done", {31'd0, done}, 32'd0);
      check("mid_rst_ferr", {31'd0, frame_err}, 32'd0);
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
      tick(5);
      reset = 1'b1;
      tick(20);
      send_frame(8'h3B, 1'b0, 1'b1, 11, 1'b0);
      tick(900);
      check("t6_tasta_b", {24'd0, tasta}, 32'h3B);
      check("t6_rises_b", done_rises, 8);
      check("t6_len", last_len, DONE_HOLD);
      check("t6_err", err_pulses, 2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
